vin_frequency: RTL and testbench
================================

# vin_frequency

Frequency/period input counter for the RIO firmware: the receive-side counterpart of the frequency output generator. It measures an external square/pulse signal (encoder index, flow meter, spindle tach) on a board pin and publishes the result as a 32-bit value the host protocol reads back. It uses two methods together: a gated edge count reported in Hz, and a per-edge period count reported in clock cycles, with a timeout for a stopped input.

## Interface
- CLK_FREQ, 100000000: system clock frequency in Hz.
- GATE_DIV, 10: gate windows per second. Gate length GATE_LEN = CLK_FREQ/GATE_DIV cycles, which must divide exactly.
- TIMEOUT, 100000000: cycles without a rising edge before the input is declared stopped.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- SIGNAL  in  1  asynchronous external input.
- disabled  in  1  when high, measurement is halted and cleared.
- frequency  out  signed [31:0]  last gated result in Hz, always ≥ 0.
- period  out  32  clk cycles between the last two rising edges; 0 means none/stopped.
- valid  out  1  one-cycle pulse marking that `frequency` was updated.
- timeout  out  1  level; high while no edge has arrived for TIMEOUT cycles.

## Operation
- **Input conditioning.** SIGNAL passes through a 2-flop synchronizer, then a registered rising-edge detect (`edge`). The minimum resolvable period is 2 cycles.
- **Gate counter.** `gate_cnt` runs 0..GATE_LEN-1 and wraps. `edge_cnt` increments on each `edge` and saturates at 2^32-1.
- **Gate end.** In the cycle where `gate_cnt == GATE_LEN-1`:
  - `frequency <= (edge_cnt + edge) * GATE_DIV`, truncated to 31 bits with saturation at 2^31-1.
  - `edge_cnt <= 0`.
  - `valid <= 1`.
  - An edge in that same cycle is counted in the closing gate.
- **Period counter.** `period_cnt` increments every cycle and saturates at TIMEOUT.
  - On `edge`: if `armed`, `period <= period_cnt + 1`. In all cases `period_cnt <= 0`, `armed <= 1`, `timeout <= 0`.
- **Timeout.** When `period_cnt == TIMEOUT-1` with no edge: `timeout <= 1`, `period <= 0`, `armed <= 0`. `frequency` reaches 0 naturally at the next gate end.
- **Period state machine.**
  - IDLE (`armed` = 0): go to ARMED on edge.
  - ARMED: update `period` on each edge; return to IDLE on timeout.
- **Disabled.** While `disabled` = 1, all counters, the synchronizer history and `armed` are held at 0, and all outputs are 0. After `disabled` falls, the gate restarts at `gate_cnt` = 0.
- **Reset.** Same clearing as `disabled`. Reset values: `frequency` = 0, `period` = 0, `valid` = 0, `timeout` = 0.

## Timing
- SIGNAL rising to `edge` asserted: 3 clk cycles.
- `edge` to `period` updated: 1 cycle.
- Gate-end cycle to `frequency`/`valid` visible: 1 cycle. `valid` is high for exactly 1 cycle every GATE_LEN cycles.
- After reset or `disabled` deasserts, the first `valid` comes GATE_LEN cycles later. The first real `period` needs two edges.
- `timeout` rises exactly TIMEOUT cycles after the last `edge`, or after the release of reset/`disabled` if no edge follows.
- Reset or `disabled` asserted mid-gate takes effect on the next clock edge and overrides every simultaneous event.

## Structure
- GATE_LEN and counter widths are localparams derived in the module. They are not shared, because no other block needs them.
- Shared package/header holds only the common 32-bit measurement width constant used by the host register map.
- Sub-module `vin_sync_edge` contains the 2-flop synchronizer plus the rising-edge register. Output: a 1-cycle `edge` pulse. It has its own `reset`.

## Test plan
Bench parameters: CLK_FREQ=1000, GATE_DIV=10 (GATE_LEN=100), TIMEOUT=500.
1. Square wave with a 20-cycle period, held for 5 gates → `frequency` = 50 from the 2nd `valid` onward, `period` = 20, `timeout` = 0.
2. Input held low after reset → `timeout` = 1 at cycle 500, `period` = 0, every `valid` shows `frequency` = 0.
3. Single edge placed in cycle `gate_cnt` = 99 with no others in that gate → `frequency` = 10 at that `valid`, and 0 at the next.
4. Edges every 20 cycles, then reset asserted mid-period → all outputs 0 next cycle. The first edge after release leaves `period` = 0; the second sets it to 20.
5. `disabled` pulsed for 30 cycles mid-gate during a 20-cycle input → outputs 0 while high. The first `valid` comes 100 cycles after release and shows 50 (edge alignment permitting 50±10).
6. 2-cycle period (maximum rate) → `period` = 2, `frequency` = 500.

Source files
------------

// File: rtl/vin_frequency_pkg.sv
// Measurement width shared with the host register map.
package vin_frequency_pkg;
    localparam int MEAS_W = 32;
endpackage

// File: rtl/vin_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detect.
// SIGNAL rise to rise pulse takes 3 clk cycles; no backpressure.
module vin_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);
    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= sig_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/vin_frequency.sv
// Input frequency/period meter: gated edge count in Hz plus per-edge period in clk cycles.
// Results are registered one cycle after the gate end or edge; no backpressure.
module vin_frequency
    import vin_frequency_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int GATE_DIV = 10,
    parameter int TIMEOUT  = 100000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     SIGNAL,
    input  logic                     disabled,
    output logic signed [MEAS_W-1:0] frequency,
    output logic        [MEAS_W-1:0] period,
    output logic                     valid,
    output logic                     timeout
);
    localparam int GATE_LEN = CLK_FREQ / GATE_DIV;
    localparam int GATE_W   = $clog2(GATE_LEN);
    localparam int PER_W    = $clog2(TIMEOUT + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_LEN - 1);
    localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(TIMEOUT - 1);
    localparam logic [31:0]       GATE_MULT = 32'(GATE_DIV);
    localparam logic [63:0]       FREQ_MAX  = 64'h0000_0000_7FFF_FFFF;

    typedef enum logic {IDLE, ARMED} per_state_t;

    per_state_t        state;
    logic              clear;
    logic              rise;
    logic              armed;
    logic [GATE_W-1:0] gate_cnt;
    logic [MEAS_W-1:0] edge_cnt;
    logic [PER_W-1:0]  period_cnt;
    logic [MEAS_W:0]   edge_sum;
    logic [63:0]       scaled;
    logic [MEAS_W-1:0] freq_next;

    assign clear = reset | disabled;
    assign armed = (state == ARMED);

    vin_sync_edge u_sync (
        .clk    (clk),
        .reset  (clear),
        .sig_in (SIGNAL),
        .rise   (rise)
    );

    // An edge landing on the gate-end cycle still belongs to the closing gate.
    always_comb begin
        edge_sum  = {1'b0, edge_cnt} + (MEAS_W + 1)'(rise);
        scaled    = 64'(edge_sum) * 64'(GATE_MULT);
        freq_next = (scaled > FREQ_MAX) ? FREQ_MAX[MEAS_W-1:0] : scaled[MEAS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            period_cnt <= '0;
            state      <= IDLE;
            frequency  <= '0;
            period     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (gate_cnt == GATE_LAST) begin
                gate_cnt  <= '0;
                edge_cnt  <= '0;
                frequency <= freq_next;
                valid     <= 1'b1;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                if (rise && !(&edge_cnt))
                    edge_cnt <= edge_cnt + MEAS_W'(1);
            end

            if (rise) begin
                period_cnt <= '0;
                timeout    <= 1'b0;
                state      <= ARMED;
                if (armed)
                    period <= MEAS_W'(period_cnt) + MEAS_W'(1);
            end else begin
                if (period_cnt != PER_MAX)
                    period_cnt <= period_cnt + PER_W'(1);
                if (period_cnt == PER_LAST) begin
                    timeout <= 1'b1;
                    period  <= '0;
                    state   <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_vin_frequency.sv
// Directed bench for vin_frequency with GATE_LEN=100 and TIMEOUT=500.
module tb_vin_frequency;
    import vin_frequency_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic sig;
    logic disabled;
    logic signed [MEAS_W-1:0] frequency;
    logic [MEAS_W-1:0] period;
    logic valid;
    logic timeout;

    int checks = 0;
    int errors = 0;
    bit sq_en = 1'b0;
    int half = 10;
    int ph = 0;
    int nval;

    always #5 clk = ~clk;

    vin_frequency #(
        .CLK_FREQ (1000),
        .GATE_DIV (10),
        .TIMEOUT  (500)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SIGNAL    (sig),
        .disabled  (disabled),
        .frequency (frequency),
        .period    (period),
        .valid     (valid),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the edge; drives the square wave.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sq_en) begin
                ph++;
                if (ph >= half) begin
                    sig = ~sig;
                    ph  = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        disabled = 1'b0;
        sq_en    = 1'b0;
        sig      = 1'b0;
        ph       = 0;
        step(3);
        reset = 1'b0;
    endtask

    task automatic start_sq(input int h);
        half  = h;
        sig   = 1'b0;
        ph    = 0;
        sq_en = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        disabled = 1'b0;
        sig      = 1'b0;
        step(3);
        chk("rst_freq", frequency, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);

        // Input held low after reset
        do_reset();
        step(99);
        chk("t2_valid_99", {31'd0, valid}, 0);
        step(1);
        chk("t2_valid_100", {31'd0, valid}, 1);
        chk("t2_freq_100", frequency, 0);
        step(1);
        chk("t2_valid_101", {31'd0, valid}, 0);
        step(398);
        chk("t2_timeout_499", {31'd0, timeout}, 0);
        step(1);
        chk("t2_timeout_500", {31'd0, timeout}, 1);
        chk("t2_period_500", period, 0);
        chk("t2_valid_500", {31'd0, valid}, 1);
        chk("t2_freq_500", frequency, 0);
        sig = 1'b1;
        step(6);
        chk("t2_timeout_clear", {31'd0, timeout}, 0);
        chk("t2_period_first_edge", period, 0);

        // 20-cycle square wave for five gates
        do_reset();
        start_sq(10);
        nval = 0;
        for (int i = 1; i <= 500; i++) begin
            step(1);
            if (valid) begin
                nval++;
                if (nval >= 2)
                    chk("t1_freq", frequency, 50);
            end
        end
        chk("t1_nvalid", nval, 5);
        chk("t1_period", period, 20);
        chk("t1_timeout", {31'd0, timeout}, 0);

        // Single edge on the last cycle of the gate
        do_reset();
        step(96);
        sig = 1'b1;
        step(4);
        chk("t3_valid", {31'd0, valid}, 1);
        chk("t3_freq_edge99", frequency, 10);
        step(100);
        chk("t3_valid_next", {31'd0, valid}, 1);
        chk("t3_freq_next", frequency, 0);

        // Reset mid-period
        do_reset();
        start_sq(10);
        step(250);
        chk("t4_period_pre", period, 20);
        chk("t4_freq_pre", frequency, 50);
        reset = 1'b1;
        step(1);
        chk("t4_freq_rst", frequency, 0);
        chk("t4_period_rst", period, 0);
        chk("t4_valid_rst", {31'd0, valid}, 0);
        chk("t4_timeout_rst", {31'd0, timeout}, 0);
        sq_en = 1'b0;
        sig   = 1'b0;
        step(4);
        reset = 1'b0;
        start_sq(10);
        step(25);
        chk("t4_period_one_edge", period, 0);
        step(15);
        chk("t4_period_two_edges", period, 20);

        // Disabled pulse mid-gate
        do_reset();
        start_sq(10);
        step(150);
        chk("t5_freq_pre", frequency, 50);
        disabled = 1'b1;
        step(1);
        chk("t5_freq_dis", frequency, 0);
        chk("t5_period_dis", period, 0);
        chk("t5_timeout_dis", {31'd0, timeout}, 0);
        nval = 0;
        for (int i = 0; i < 29; i++) begin
            step(1);
            if (valid) nval++;
        end
        chk("t5_valid_dis", nval, 0);
        chk("t5_freq_dis_end", frequency, 0);
        disabled = 1'b0;
        nval = 0;
        for (int i = 0; i < 99; i++) begin
            step(1);
            if (valid) nval++;
        end
        chk("t5_no_early_valid", nval, 0);
        step(1);
        chk("t5_valid_release", {31'd0, valid}, 1);
        chk("t5_freq_range", {31'd0, (frequency >= 40 && frequency <= 60)}, 1);

        // Maximum rate: 2-cycle period
        do_reset();
        start_sq(1);
        step(200);
        chk("t6_valid", {31'd0, valid}, 1);
        chk("t6_freq", frequency, 500);
        chk("t6_period", period, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
